peak_window_sorter: RTL and testbench
=====================================

Name: peak_window_sorter

Overview:
- Sequential, parametrised reorder engine for the interferometer peak-window path.
- Takes N_CH peak candidates per frame. Each candidate has a max-position key plus start/end window bounds.
- frequency_mode=1: sorts candidates ascending by key. frequency_mode=0: applies the fixed channel 0/1 swap.
- Sits between peak search and window integration. Replaces the combinational 3-channel reorder with a registered, handshaked, N-channel block that has stable tie handling and a permutation output.

Parameters:
- N_CH, 3, number of candidate channels (legal range 2..16).
- W, 8, width of key, start and end position fields.
- IDXW (localparam), $clog2(N_CH), width of one permutation index.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- frequency_mode  in  1  1 = sort by key, 0 = fixed swap of channels 0 and 1; sampled with start
- in_key  in  N_CH*W  max-position keys; channel i at [i*W +: W]
- in_start  in  N_CH*W  window start positions, same packing as in_key
- in_end  in  N_CH*W  window end positions, same packing as in_key
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the outputs update
- out_key  out  N_CH*W  reordered keys; slot 0 holds the smallest key
- out_start  out  N_CH*W  reordered start positions
- out_end  out  N_CH*W  reordered end positions
- out_perm  out  N_CH*IDXW  source channel index for each output slot

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0; done=0; out_key/out_start/out_end all 0; out_perm slot i = i (identity). Working registers are cleared the same way.
- FSM has three states: IDLE, SORT, FLUSH.
- IDLE with start=1 at edge k:
  - Capture in_key, in_start, in_end and frequency_mode into working registers.
  - Set working perm to identity and pass counter to 0.
  - Go to SORT if mode=1, otherwise FLUSH.
  - busy=1 from edge k onward.
- SORT: one odd-even transposition pass per clock.
  - Even pass p compares pairs (0,1),(2,3),...
  - Odd pass p compares pairs (1,2),(3,4),...
  - Swap a pair only if key[lo] > key[hi] (strict). Equal keys keep capture order, so the sort is stable.
  - Key, start, end and perm move together as one record.
  - After pass N_CH-1 the state goes to FLUSH. Exactly N_CH passes run, fixed, with no early exit.
- FLUSH with captured mode=0: swap records 0 and 1; slots 2..N_CH-1 pass through unchanged.
- FLUSH, both modes:
  - Register the working records into the out_* ports.
  - done=1 for exactly one cycle; busy=0; next state IDLE.
- Latency, start sampled at edge k:
  - Mode 1: outputs and done valid after edge k+N_CH+1.
  - Mode 0: outputs and done valid after edge k+1.
- start while busy=1: ignored and not queued. in_* and frequency_mode changes while busy have no effect.
- start on the same cycle done=1 (state is FLUSH): ignored. The earliest accepted restart is the cycle after done.
- Outputs hold their values between done pulses.
- Reset mid-operation: immediate return to reset values. No done pulse, and no partial result reaches the outputs.
- Keys compare as unsigned W-bit values; no arithmetic, no width growth.
- out_perm values are always a permutation of 0..N_CH-1.

Test Plan:
- Ascending sort, N_CH=3, W=8, mode=1:
  - Stimulus: keys {50,20,80}, starts {45,15,75}, ends {55,25,85}.
  - Required: done exactly 4 edges after start. out_key={20,50,80}, out_start={15,45,75}, out_end={25,55,85}, out_perm={1,0,2}.
- Reverse input and ties, mode=1:
  - Keys {90,60,30}: out_key={30,60,90}, out_perm={2,1,0}.
  - Then keys {40,40,10}: out_key={10,40,40}, out_perm={2,0,1} (stable).
- Fixed swap, mode=0:
  - Stimulus: keys {50,20,80}, starts {45,15,75}.
  - Required: done 1 edge after start, with busy=1 in between. out_key={20,50,80}, out_start={15,45,75}, out_perm={1,0,2}.
  - Repeat with keys {10,20,30}: out_key={20,10,30} (swap regardless of order).
- Handshake:
  - Start a mode=1 sort; during SORT pulse start again with different keys.
  - Required: second request ignored, one done only, result from the first keys.
  - Then start on the cycle after done: accepted.
- Reset mid-sort:
  - Deassert rst_n two cycles after start.
  - Required: busy=0, done never pulses, out_key=0, out_perm={0,1,2}.
  - Then a normal sort completes correctly.
- N_CH=5, mode=1:
  - Stimulus: keys {200,150,100,50,0}.
  - Required: done 6 edges after start. out_key={0,50,100,150,200}, out_perm={4,3,2,1,0}.

Source files
------------

// File: rtl/peak_window_sorter_if.sv
// Handshake and data bus for peak_window_sorter: per-frame candidate records in,
// reordered records plus source permutation out.
interface peak_window_sorter_if #(
  parameter int N_CH = 3,
  parameter int W    = 8
);
  localparam int IDXW = $clog2(N_CH);

  logic                 start;
  logic                 frequency_mode;
  logic [N_CH*W-1:0]    in_key;
  logic [N_CH*W-1:0]    in_start;
  logic [N_CH*W-1:0]    in_end;
  logic                 busy;
  logic                 done;
  logic [N_CH*W-1:0]    out_key;
  logic [N_CH*W-1:0]    out_start;
  logic [N_CH*W-1:0]    out_end;
  logic [N_CH*IDXW-1:0] out_perm;

  modport master (
    output start, frequency_mode, in_key, in_start, in_end,
    input  busy, done, out_key, out_start, out_end, out_perm
  );

  modport slave (
    input  start, frequency_mode, in_key, in_start, in_end,
    output busy, done, out_key, out_start, out_end, out_perm
  );
endinterface

// File: rtl/peak_window_sorter.sv
// Registered N-channel peak-window reorder: stable odd-even transposition sort by key,
// or a fixed channel 0/1 swap, with a source-permutation output.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last result
// SORT  | one odd-even transposition pass per clock, exactly N_CH passes
// FLUSH | apply optional 0/1 swap, register result, pulse done
module peak_window_sorter #(
  parameter int N_CH = 3,
  parameter int W    = 8
) (
  input logic                clk,
  input logic                rst_n,
  peak_window_sorter_if.slave bus
);
  localparam int IDXW = $clog2(N_CH);
  localparam int PW   = $clog2(N_CH) + 1;

  typedef enum logic [1:0] {IDLE, SORT, FLUSH} state_t;

  state_t          state;
  logic            mode_r;
  logic [PW-1:0]   pass_cnt;
  logic            busy_r;
  logic            done_r;

  logic [W-1:0]    wk_key   [N_CH];
  logic [W-1:0]    wk_start [N_CH];
  logic [W-1:0]    wk_end   [N_CH];
  logic [IDXW-1:0] wk_perm  [N_CH];

  logic [W-1:0]    nx_key   [N_CH];
  logic [W-1:0]    nx_start [N_CH];
  logic [W-1:0]    nx_end   [N_CH];
  logic [IDXW-1:0] nx_perm  [N_CH];

  logic [W-1:0]    fl_key   [N_CH];
  logic [W-1:0]    fl_start [N_CH];
  logic [W-1:0]    fl_end   [N_CH];
  logic [IDXW-1:0] fl_perm  [N_CH];

  logic [N_CH*W-1:0]    out_key_r;
  logic [N_CH*W-1:0]    out_start_r;
  logic [N_CH*W-1:0]    out_end_r;
  logic [N_CH*IDXW-1:0] out_perm_r;

  // Pairs within one pass are disjoint, so every swap reads the unmodified working set.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      nx_key[i]   = wk_key[i];
      nx_start[i] = wk_start[i];
      nx_end[i]   = wk_end[i];
      nx_perm[i]  = wk_perm[i];
    end
    for (int i = 0; i < N_CH - 1; i++) begin
      if ((i[0] == pass_cnt[0]) && (wk_key[i] > wk_key[i+1])) begin
        nx_key[i]     = wk_key[i+1];
        nx_key[i+1]   = wk_key[i];
        nx_start[i]   = wk_start[i+1];
        nx_start[i+1] = wk_start[i];
        nx_end[i]     = wk_end[i+1];
        nx_end[i+1]   = wk_end[i];
        nx_perm[i]    = wk_perm[i+1];
        nx_perm[i+1]  = wk_perm[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      fl_key[i]   = wk_key[i];
      fl_start[i] = wk_start[i];
      fl_end[i]   = wk_end[i];
      fl_perm[i]  = wk_perm[i];
    end
    if (!mode_r) begin
      fl_key[0]   = wk_key[1];
      fl_key[1]   = wk_key[0];
      fl_start[0] = wk_start[1];
      fl_start[1] = wk_start[0];
      fl_end[0]   = wk_end[1];
      fl_end[1]   = wk_end[0];
      fl_perm[0]  = wk_perm[1];
      fl_perm[1]  = wk_perm[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mode_r   <= 1'b0;
      pass_cnt <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        wk_key[i]   <= '0;
        wk_start[i] <= '0;
        wk_end[i]   <= '0;
        wk_perm[i]  <= IDXW'(i);
        out_perm_r[i*IDXW +: IDXW] <= IDXW'(i);
      end
      out_key_r   <= '0;
      out_start_r <= '0;
      out_end_r   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            for (int i = 0; i < N_CH; i++) begin
              wk_key[i]   <= bus.in_key[i*W +: W];
              wk_start[i] <= bus.in_start[i*W +: W];
              wk_end[i]   <= bus.in_end[i*W +: W];
              wk_perm[i]  <= IDXW'(i);
            end
            mode_r   <= bus.frequency_mode;
            pass_cnt <= '0;
            busy_r   <= 1'b1;
            state    <= bus.frequency_mode ? SORT : FLUSH;
          end
        end
        SORT: begin
          for (int i = 0; i < N_CH; i++) begin
            wk_key[i]   <= nx_key[i];
            wk_start[i] <= nx_start[i];
            wk_end[i]   <= nx_end[i];
            wk_perm[i]  <= nx_perm[i];
          end
          pass_cnt <= pass_cnt + PW'(1);
          if (pass_cnt == PW'(N_CH - 1)) state <= FLUSH;
        end
        FLUSH: begin
          for (int i = 0; i < N_CH; i++) begin
            out_key_r[i*W +: W]        <= fl_key[i];
            out_start_r[i*W +: W]      <= fl_start[i];
            out_end_r[i*W +: W]        <= fl_end[i];
            out_perm_r[i*IDXW +: IDXW] <= fl_perm[i];
          end
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.out_key   = out_key_r;
  assign bus.out_start = out_start_r;
  assign bus.out_end   = out_end_r;
  assign bus.out_perm  = out_perm_r;
endmodule

// File: tb/tb_peak_window_sorter.sv
// Scoreboard bench for peak_window_sorter: N_CH=3 and N_CH=5 instances, directed vectors.
module tb_peak_window_sorter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [39:0] key;
    logic [39:0] st;
    logic [39:0] en;
    logic [14:0] perm;
    int          cyc;
  } exp_t;

  exp_t q3[$];
  exp_t q5[$];

  peak_window_sorter_if #(.N_CH(3), .W(8)) if3 ();
  peak_window_sorter_if #(.N_CH(5), .W(8)) if5 ();

  peak_window_sorter #(.N_CH(3), .W(8)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
  peak_window_sorter #(.N_CH(5), .W(8)) dut5 (.clk(clk), .rst_n(rst_n), .bus(if5.slave));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [23:0] p3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return {c, b, a};
  endfunction

  function automatic logic [5:0] pp3(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    return {c, b, a};
  endfunction

  always @(negedge clk) begin : mon3
    exp_t x;
    if (rst_n && if3.done) begin
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done3 actual=done required=no_done (t=%0t)", $time);
      end else begin
        x = q3.pop_front();
        chk("key3",   64'(if3.out_key),   64'(x.key));
        chk("start3", 64'(if3.out_start), 64'(x.st));
        chk("end3",   64'(if3.out_end),   64'(x.en));
        chk("perm3",  64'(if3.out_perm),  64'(x.perm));
        chk("lat3",   64'(cyc),           64'(x.cyc));
        chk("busy_at_done3", 64'(if3.busy), 64'd0);
      end
    end
  end

  always @(negedge clk) begin : mon5
    exp_t x;
    if (rst_n && if5.done) begin
      if (q5.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done5 actual=done required=no_done (t=%0t)", $time);
      end else begin
        x = q5.pop_front();
        chk("key5",   64'(if5.out_key),   64'(x.key));
        chk("start5", 64'(if5.out_start), 64'(x.st));
        chk("perm5",  64'(if5.out_perm),  64'(x.perm));
        chk("lat5",   64'(cyc),           64'(x.cyc));
      end
    end
  end

  // Called at a negedge; start is sampled at the following posedge.
  task automatic go3(input logic m, input logic [23:0] k, input logic [23:0] s, input logic [23:0] e,
                     input logic [23:0] ek, input logic [23:0] es, input logic [23:0] ee,
                     input logic [5:0] ep, input int hold);
    exp_t x;
    if3.frequency_mode = m;
    if3.in_key   = k;
    if3.in_start = s;
    if3.in_end   = e;
    if3.start    = 1'b1;
    x.key  = 40'(ek);
    x.st   = 40'(es);
    x.en   = 40'(ee);
    x.perm = 15'(ep);
    x.cyc  = cyc + 1 + (m ? 4 : 1);
    q3.push_back(x);
    @(negedge clk);
    chk("busy_after_start3", 64'(if3.busy), 64'd1);
    if (hold > 1) @(negedge clk);
    if3.start          = 1'b0;
    if3.frequency_mode = ~m;
    if3.in_key   = 24'($urandom);
    if3.in_start = 24'($urandom);
    if3.in_end   = 24'($urandom);
  endtask

  task automatic raw3(input logic m, input logic [23:0] k);
    if3.frequency_mode = m;
    if3.in_key = k;
    if3.start  = 1'b1;
    @(negedge clk);
    if3.start  = 1'b0;
  endtask

  task automatic drain3();
    int n = 0;
    while (q3.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain3", 64'(q3.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    exp_t x;
    int   n;
    if3.start = 1'b0; if3.frequency_mode = 1'b0;
    if3.in_key = '0; if3.in_start = '0; if3.in_end = '0;
    if5.start = 1'b0; if5.frequency_mode = 1'b0;
    if5.in_key = '0; if5.in_start = '0; if5.in_end = '0;

    repeat (2) @(negedge clk);
    chk("rst_busy",  64'(if3.busy),    64'd0);
    chk("rst_done",  64'(if3.done),    64'd0);
    chk("rst_key",   64'(if3.out_key), 64'd0);
    chk("rst_end",   64'(if3.out_end), 64'd0);
    chk("rst_perm",  64'(if3.out_perm), 64'(pp3(0, 1, 2)));
    chk("rst_perm5", 64'(if5.out_perm), 64'({3'd4, 3'd3, 3'd2, 3'd1, 3'd0}));
    rst_n = 1'b1;
    @(negedge clk);

    // ascending sort
    go3(1'b1, p3(50, 20, 80), p3(45, 15, 75), p3(55, 25, 85),
        p3(20, 50, 80), p3(15, 45, 75), p3(25, 55, 85), pp3(1, 0, 2), 1);
    drain3();
    chk("hold_key", 64'(if3.out_key), 64'(p3(20, 50, 80)));

    // reverse input, then ties
    go3(1'b1, p3(90, 60, 30), p3(9, 6, 3), p3(99, 66, 33),
        p3(30, 60, 90), p3(3, 6, 9), p3(33, 66, 99), pp3(2, 1, 0), 1);
    drain3();
    go3(1'b1, p3(40, 40, 10), p3(1, 2, 3), p3(4, 5, 6),
        p3(10, 40, 40), p3(3, 1, 2), p3(6, 4, 5), pp3(2, 0, 1), 1);
    drain3();

    // fixed swap; second variant holds start into FLUSH, which must be ignored
    go3(1'b0, p3(50, 20, 80), p3(45, 15, 75), p3(55, 25, 85),
        p3(20, 50, 80), p3(15, 45, 75), p3(25, 55, 85), pp3(1, 0, 2), 1);
    drain3();
    go3(1'b0, p3(10, 20, 30), p3(1, 2, 3), p3(4, 5, 6),
        p3(20, 10, 30), p3(2, 1, 3), p3(5, 4, 6), pp3(1, 0, 2), 2);
    drain3();

    // start during SORT ignored; restart right after done accepted
    go3(1'b1, p3(7, 5, 6), p3(17, 15, 16), p3(27, 25, 26),
        p3(5, 6, 7), p3(15, 16, 17), p3(25, 26, 27), pp3(1, 2, 0), 1);
    raw3(1'b1, p3(1, 2, 3));
    n = 0;
    while (!if3.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(if3.done), 64'd1);
    go3(1'b1, p3(3, 2, 1), p3(13, 12, 11), p3(23, 22, 21),
        p3(1, 2, 3), p3(11, 12, 13), p3(21, 22, 23), pp3(2, 1, 0), 1);
    drain3();

    // reset mid-sort
    raw3(1'b1, p3(9, 8, 7));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(if3.busy),     64'd0);
    chk("midrst_done", 64'(if3.done),     64'd0);
    chk("midrst_key",  64'(if3.out_key),  64'd0);
    chk("midrst_perm", 64'(if3.out_perm), 64'(pp3(0, 1, 2)));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("postrst_key", 64'(if3.out_key), 64'd0);
    go3(1'b1, p3(50, 20, 80), p3(45, 15, 75), p3(55, 25, 85),
        p3(20, 50, 80), p3(15, 45, 75), p3(25, 55, 85), pp3(1, 0, 2), 1);
    drain3();

    // N_CH=5 reverse input
    if5.frequency_mode = 1'b1;
    if5.in_key   = {8'd0, 8'd50, 8'd100, 8'd150, 8'd200};
    if5.in_start = {8'd1, 8'd51, 8'd101, 8'd151, 8'd201};
    if5.in_end   = '0;
    if5.start    = 1'b1;
    x.key  = 40'({8'd200, 8'd150, 8'd100, 8'd50, 8'd0});
    x.st   = 40'({8'd201, 8'd151, 8'd101, 8'd51, 8'd1});
    x.en   = '0;
    x.perm = 15'({3'd0, 3'd1, 3'd2, 3'd3, 3'd4});
    x.cyc  = cyc + 1 + 6;
    q5.push_back(x);
    @(negedge clk);
    chk("busy_after_start5", 64'(if5.busy), 64'd1);
    if5.start  = 1'b0;
    if5.in_key = '1;
    n = 0;
    while (q5.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain5", 64'(q5.size()), 64'd0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
